peak_dpu_dsp_sbd: RTL and testbench

Parametrised successor to the dual-issue dispatch hazard logic. It keeps a per-register pending scoreboard for long-latency writers (mul, div, load), plus internal busy/occupancy tracking for mul, div and LSU. Each cycle it decides whether the instruction pair in the dispatch stage issues as 0, 1 or 2 instructions. It sits between decode and the execute units, and the scoreboard state replaces the busy/ex-address inputs the previous generation took.

---
 rtl/peak_dpu_dsp_sbd.sv | 208 ++++++++++++++++++++
 tb/tb_peak_dpu_dsp_sbd.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_dpu_dsp_sbd.sv
// Dual-issue dispatch hazard unit with a per-register pending scoreboard for
// long-latency writers (mul, div, load) and mul/div/LSU occupancy tracking.
module peak_dpu_dsp_sbd #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int LSU_OSD = 2,
    parameter bit DUAL_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic               instr0_vld,
    input  logic               instr0_rd_r0_vld,
    input  logic [REG_AW-1:0]  instr0_rd_r0_addr,
    input  logic               instr0_rd_r1_vld,
    input  logic [REG_AW-1:0]  instr0_rd_r1_addr,
    input  logic               instr0_rd_r2_vld,
    input  logic [REG_AW-1:0]  instr0_rd_r2_addr,
    input  logic               instr0_wr_vld,
    input  logic [REG_AW-1:0]  instr0_wr_addr,
    input  logic               instr0_is_mul,
    input  logic               instr0_is_div,
    input  logic               instr0_is_ld,
    input  logic               instr0_is_ls,
    input  logic               instr0_is_br,
    input  logic               instr0_is_csr,

    input  logic               instr1_vld,
    input  logic               instr1_rd_r0_vld,
    input  logic [REG_AW-1:0]  instr1_rd_r0_addr,
    input  logic               instr1_rd_r1_vld,
    input  logic [REG_AW-1:0]  instr1_rd_r1_addr,
    input  logic               instr1_rd_r2_vld,
    input  logic [REG_AW-1:0]  instr1_rd_r2_addr,
    input  logic               instr1_wr_vld,
    input  logic [REG_AW-1:0]  instr1_wr_addr,
    input  logic               instr1_is_mul,
    input  logic               instr1_is_div,
    input  logic               instr1_is_ld,
    input  logic               instr1_is_ls,
    input  logic               instr1_is_br,
    input  logic               instr1_is_csr,

    input  logic               mul_wb_vld,
    input  logic [REG_AW-1:0]  mul_wb_addr,
    input  logic               div_wb_vld,
    input  logic [REG_AW-1:0]  div_wb_addr,
    input  logic               lsu_done,
    input  logic               lsu_wb_vld,
    input  logic [REG_AW-1:0]  lsu_wb_addr,

    output logic               instr0_iss,
    output logic               instr1_iss,
    output logic [REG_NUM-1:0] sbd_pend,
    output logic [2:0]         lsu_cnt
);

    logic [REG_NUM-1:0] sbd_pend_q, sbd_pend_d;
    logic               mul_busy_q, mul_busy_d;
    logic               div_busy_q, div_busy_d;
    logic [2:0]         lsu_cnt_q, lsu_cnt_d;

    logic [REG_NUM-1:0] wb_clr;
    logic [REG_NUM-1:0] pend_eff;
    logic [REG_NUM-1:0] set_vec;
    logic               mul_free, div_free, lsu_free;
    logic [2:0]         lsu_cnt_dec;
    logic               hazard0, hazard1;
    logic               pair_block;
    logic               raw01;
    logic               class_clash;
    int                 src_total;
    logic               mul_iss, div_iss, ls_iss;

    logic [2:0]              i0_src_vld, i1_src_vld;
    logic [2:0][REG_AW-1:0]  i0_src_addr, i1_src_addr;

    assign i0_src_vld  = {instr0_rd_r2_vld, instr0_rd_r1_vld, instr0_rd_r0_vld};
    assign i1_src_vld  = {instr1_rd_r2_vld, instr1_rd_r1_vld, instr1_rd_r0_vld};
    assign i0_src_addr = {instr0_rd_r2_addr, instr0_rd_r1_addr, instr0_rd_r0_addr};
    assign i1_src_addr = {instr1_rd_r2_addr, instr1_rd_r1_addr, instr1_rd_r0_addr};

    function automatic logic calc_hazard(
        input logic [REG_NUM-1:0]       pend,
        input logic [2:0]               src_vld,
        input logic [2:0][REG_AW-1:0]   src_addr,
        input logic                     wr_vld,
        input logic [REG_AW-1:0]        wr_addr,
        input logic                     need_mul,
        input logic                     need_div,
        input logic                     need_ls,
        input logic                     mul_ok,
        input logic                     div_ok,
        input logic                     lsu_ok
    );
        logic haz;
        haz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (src_vld[k] && pend[src_addr[k]]) begin
                haz = 1'b1;
            end
        end
        if (wr_vld && pend[wr_addr]) begin
            haz = 1'b1;
        end
        if ((need_mul && !mul_ok) || (need_div && !div_ok) || (need_ls && !lsu_ok)) begin
            haz = 1'b1;
        end
        return haz;
    endfunction

    // Same-cycle writebacks are bypassed by the regfile, so they lift the hazard now.
    always_comb begin
        wb_clr = '0;
        if (mul_wb_vld) begin
            wb_clr[mul_wb_addr] = 1'b1;
        end
        if (div_wb_vld) begin
            wb_clr[div_wb_addr] = 1'b1;
        end
        if (lsu_wb_vld) begin
            wb_clr[lsu_wb_addr] = 1'b1;
        end
        pend_eff    = sbd_pend_q & ~wb_clr;
        pend_eff[0] = 1'b0;
    end

    always_comb begin
        lsu_cnt_dec = lsu_cnt_q;
        if (lsu_done && (lsu_cnt_q != 3'd0)) begin
            lsu_cnt_dec = lsu_cnt_q - 3'd1;
        end
        mul_free = ~mul_busy_q | mul_wb_vld;
        div_free = ~div_busy_q | div_wb_vld;
        lsu_free = (int'(lsu_cnt_dec) < LSU_OSD);
    end

    assign hazard0 = calc_hazard(pend_eff, i0_src_vld, i0_src_addr, instr0_wr_vld, instr0_wr_addr,
                                 instr0_is_mul, instr0_is_div, instr0_is_ls,
                                 mul_free, div_free, lsu_free);
    assign hazard1 = calc_hazard(pend_eff, i1_src_vld, i1_src_addr, instr1_wr_vld, instr1_wr_addr,
                                 instr1_is_mul, instr1_is_div, instr1_is_ls,
                                 mul_free, div_free, lsu_free);

    // Pairing rules: instr1 may not depend on instr0 or compete for a unit or regfile port.
    always_comb begin
        raw01 = 1'b0;
        if (instr0_wr_vld && (instr0_wr_addr != '0)) begin
            for (int k = 0; k < 3; k++) begin
                if (i1_src_vld[k] && (i1_src_addr[k] == instr0_wr_addr)) begin
                    raw01 = 1'b1;
                end
            end
            if (instr1_wr_vld && (instr1_wr_addr == instr0_wr_addr)) begin
                raw01 = 1'b1;
            end
        end
        class_clash = (instr0_is_mul & instr1_is_mul) | (instr0_is_div & instr1_is_div) |
                      (instr0_is_ls  & instr1_is_ls)  | (instr0_is_br  & instr1_is_br)  |
                      (instr0_is_csr & instr1_is_csr);
        src_total   = $countones({i0_src_vld, i1_src_vld});
        pair_block  = instr0_is_br | class_clash | raw01 | (src_total > 4);
    end

    assign instr0_iss = instr0_vld & ~flush & ~rst & ~hazard0;
    assign instr1_iss = DUAL_EN & instr0_iss & instr1_vld & ~hazard1 & ~pair_block;

    // A new long-latency writer overrides a same-cycle writeback to its destination.
    always_comb begin
        set_vec = '0;
        if (instr0_iss && (instr0_is_mul || instr0_is_div || instr0_is_ld) &&
            instr0_wr_vld && (instr0_wr_addr != '0)) begin
            set_vec[instr0_wr_addr] = 1'b1;
        end
        if (instr1_iss && (instr1_is_mul || instr1_is_div || instr1_is_ld) &&
            instr1_wr_vld && (instr1_wr_addr != '0)) begin
            set_vec[instr1_wr_addr] = 1'b1;
        end
        sbd_pend_d    = (sbd_pend_q & ~wb_clr) | set_vec;
        sbd_pend_d[0] = 1'b0;

        mul_iss    = (instr0_iss & instr0_is_mul) | (instr1_iss & instr1_is_mul);
        div_iss    = (instr0_iss & instr0_is_div) | (instr1_iss & instr1_is_div);
        ls_iss     = (instr0_iss & instr0_is_ls)  | (instr1_iss & instr1_is_ls);
        mul_busy_d = (mul_busy_q & ~mul_wb_vld) | mul_iss;
        div_busy_d = (div_busy_q & ~div_wb_vld) | div_iss;
        lsu_cnt_d  = lsu_cnt_dec + {2'b00, ls_iss};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sbd_pend_q <= '0;
            mul_busy_q <= 1'b0;
            div_busy_q <= 1'b0;
            lsu_cnt_q  <= 3'd0;
        end else begin
            sbd_pend_q <= sbd_pend_d;
            mul_busy_q <= mul_busy_d;
            div_busy_q <= div_busy_d;
            lsu_cnt_q  <= lsu_cnt_d;
        end
    end

    assign sbd_pend = sbd_pend_q;
    assign lsu_cnt  = lsu_cnt_q;

endmodule

// File: tb/tb_peak_dpu_dsp_sbd.sv
// Directed self-checking bench for peak_dpu_dsp_sbd; a second DUAL_EN=0
// instance shares the stimulus to show instr1 never issues in single-issue mode.
module tb_peak_dpu_dsp_sbd;

    localparam int AW = 5;
    localparam logic [5:0] CL_ALU = 6'b000000;
    localparam logic [5:0] CL_MUL = 6'b100000;
    localparam logic [5:0] CL_DIV = 6'b010000;
    localparam logic [5:0] CL_LD  = 6'b001100;
    localparam logic [5:0] CL_ST  = 6'b000100;
    localparam logic [5:0] CL_BR  = 6'b000010;
    localparam logic [5:0] CL_CSR = 6'b000001;

    logic clk = 1'b0;
    logic rst, flush;
    logic i0_vld, i0_r0_vld, i0_r1_vld, i0_r2_vld, i0_wr_vld;
    logic [AW-1:0] i0_r0, i0_r1, i0_r2, i0_wr;
    logic i0_mul, i0_div, i0_ld, i0_ls, i0_br, i0_csr;
    logic i1_vld, i1_r0_vld, i1_r1_vld, i1_r2_vld, i1_wr_vld;
    logic [AW-1:0] i1_r0, i1_r1, i1_r2, i1_wr;
    logic i1_mul, i1_div, i1_ld, i1_ls, i1_br, i1_csr;
    logic mul_wb_vld, div_wb_vld, lsu_done, lsu_wb_vld;
    logic [AW-1:0] mul_wb_addr, div_wb_addr, lsu_wb_addr;

    logic        iss0, iss1, nd_iss0, nd_iss1;
    logic [31:0] pend, nd_pend;
    logic [2:0]  cnt, nd_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peak_dpu_dsp_sbd #(.REG_NUM(32), .REG_AW(5), .LSU_OSD(2), .DUAL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .instr0_vld(i0_vld),
        .instr0_rd_r0_vld(i0_r0_vld), .instr0_rd_r0_addr(i0_r0),
        .instr0_rd_r1_vld(i0_r1_vld), .instr0_rd_r1_addr(i0_r1),
        .instr0_rd_r2_vld(i0_r2_vld), .instr0_rd_r2_addr(i0_r2),
        .instr0_wr_vld(i0_wr_vld), .instr0_wr_addr(i0_wr),
        .instr0_is_mul(i0_mul), .instr0_is_div(i0_div), .instr0_is_ld(i0_ld),
        .instr0_is_ls(i0_ls), .instr0_is_br(i0_br), .instr0_is_csr(i0_csr),
        .instr1_vld(i1_vld),
        .instr1_rd_r0_vld(i1_r0_vld), .instr1_rd_r0_addr(i1_r0),
        .instr1_rd_r1_vld(i1_r1_vld), .instr1_rd_r1_addr(i1_r1),
        .instr1_rd_r2_vld(i1_r2_vld), .instr1_rd_r2_addr(i1_r2),
        .instr1_wr_vld(i1_wr_vld), .instr1_wr_addr(i1_wr),
        .instr1_is_mul(i1_mul), .instr1_is_div(i1_div), .instr1_is_ld(i1_ld),
        .instr1_is_ls(i1_ls), .instr1_is_br(i1_br), .instr1_is_csr(i1_csr),
        .mul_wb_vld(mul_wb_vld), .mul_wb_addr(mul_wb_addr),
        .div_wb_vld(div_wb_vld), .div_wb_addr(div_wb_addr),
        .lsu_done(lsu_done), .lsu_wb_vld(lsu_wb_vld), .lsu_wb_addr(lsu_wb_addr),
        .instr0_iss(iss0), .instr1_iss(iss1), .sbd_pend(pend), .lsu_cnt(cnt)
    );

    peak_dpu_dsp_sbd #(.REG_NUM(32), .REG_AW(5), .LSU_OSD(2), .DUAL_EN(1'b0)) dut_single (
        .clk(clk), .rst(rst), .flush(flush),
        .instr0_vld(i0_vld),
        .instr0_rd_r0_vld(i0_r0_vld), .instr0_rd_r0_addr(i0_r0),
        .instr0_rd_r1_vld(i0_r1_vld), .instr0_rd_r1_addr(i0_r1),
        .instr0_rd_r2_vld(i0_r2_vld), .instr0_rd_r2_addr(i0_r2),
        .instr0_wr_vld(i0_wr_vld), .instr0_wr_addr(i0_wr),
        .instr0_is_mul(i0_mul), .instr0_is_div(i0_div), .instr0_is_ld(i0_ld),
        .instr0_is_ls(i0_ls), .instr0_is_br(i0_br), .instr0_is_csr(i0_csr),
        .instr1_vld(i1_vld),
        .instr1_rd_r0_vld(i1_r0_vld), .instr1_rd_r0_addr(i1_r0),
        .instr1_rd_r1_vld(i1_r1_vld), .instr1_rd_r1_addr(i1_r1),
        .instr1_rd_r2_vld(i1_r2_vld), .instr1_rd_r2_addr(i1_r2),
        .instr1_wr_vld(i1_wr_vld), .instr1_wr_addr(i1_wr),
        .instr1_is_mul(i1_mul), .instr1_is_div(i1_div), .instr1_is_ld(i1_ld),
        .instr1_is_ls(i1_ls), .instr1_is_br(i1_br), .instr1_is_csr(i1_csr),
        .mul_wb_vld(mul_wb_vld), .mul_wb_addr(mul_wb_addr),
        .div_wb_vld(div_wb_vld), .div_wb_addr(div_wb_addr),
        .lsu_done(lsu_done), .lsu_wb_vld(lsu_wb_vld), .lsu_wb_addr(lsu_wb_addr),
        .instr0_iss(nd_iss0), .instr1_iss(nd_iss1), .sbd_pend(nd_pend), .lsu_cnt(nd_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        flush = 1'b0;
        {i0_vld, i0_r0_vld, i0_r1_vld, i0_r2_vld, i0_wr_vld} = '0;
        {i0_r0, i0_r1, i0_r2, i0_wr} = '0;
        {i0_mul, i0_div, i0_ld, i0_ls, i0_br, i0_csr} = '0;
        {i1_vld, i1_r0_vld, i1_r1_vld, i1_r2_vld, i1_wr_vld} = '0;
        {i1_r0, i1_r1, i1_r2, i1_wr} = '0;
        {i1_mul, i1_div, i1_ld, i1_ls, i1_br, i1_csr} = '0;
        {mul_wb_vld, div_wb_vld, lsu_done, lsu_wb_vld} = '0;
        {mul_wb_addr, div_wb_addr, lsu_wb_addr} = '0;
    endtask

    // cls = {mul, div, ld, ls, br, csr}; src_vld bit k enables source k
    task automatic applyStimulus(input int slot, input logic vld, input logic wr_vld,
                                 input logic [AW-1:0] wr, input logic [2:0] src_vld,
                                 input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                                 input logic [AW-1:0] s2, input logic [5:0] cls);
        if (slot == 0) begin
            i0_vld = vld; i0_wr_vld = wr_vld; i0_wr = wr;
            {i0_r2_vld, i0_r1_vld, i0_r0_vld} = src_vld;
            i0_r0 = s0; i0_r1 = s1; i0_r2 = s2;
            {i0_mul, i0_div, i0_ld, i0_ls, i0_br, i0_csr} = cls;
        end else begin
            i1_vld = vld; i1_wr_vld = wr_vld; i1_wr = wr;
            {i1_r2_vld, i1_r1_vld, i1_r0_vld} = src_vld;
            i1_r0 = s0; i1_r1 = s1; i1_r2 = s2;
            {i1_mul, i1_div, i1_ld, i1_ls, i1_br, i1_csr} = cls;
        end
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;
        applyStimulus(0, 1, 1, 5'd3, 3'b011, 5'd1, 5'd2, 5'd0, CL_ALU);
        repeat (2) @(negedge clk);
        #1 checkOutput("rst_iss0", iss0, 0);
        rst = 1'b0;
        #1 checkOutput("reset_pend", pend, 0);
        checkOutput("reset_lsu_cnt", cnt, 0);

        // ALU pair dual-issues
        applyStimulus(1, 1, 1, 5'd4, 3'b001, 5'd5, 5'd0, 5'd0, CL_ALU);
        #1 checkOutput("alu_pair_iss0", iss0, 1);
        checkOutput("alu_pair_iss1", iss1, 1);
        checkOutput("alu_pair_pend", pend, 0);
        checkOutput("single_iss0", nd_iss0, 1);
        checkOutput("single_iss1", nd_iss1, 0);

        // mul x7, then a dependent read stalls until the writeback bypass
        @(negedge clk); idleInputs();
        applyStimulus(0, 1, 1, 5'd7, 3'b001, 5'd1, 5'd0, 5'd0, CL_MUL);
        #1 checkOutput("mul7_iss0", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("mul7_pend", pend, 32'h0000_0080);
        applyStimulus(0, 1, 1, 5'd11, 3'b001, 5'd1, 5'd0, 5'd0, CL_MUL);
        #1 checkOutput("mul_busy_stall", iss0, 0);
        applyStimulus(0, 1, 1, 5'd8, 3'b001, 5'd7, 5'd0, 5'd0, CL_ALU);
        #1 checkOutput("raw_x7_stall", iss0, 0);
        mul_wb_vld = 1'b1; mul_wb_addr = 5'd7;
        #1 checkOutput("raw_x7_bypass", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("mul7_cleared", pend, 0);

        // Two loads fill the LSU; a store waits until lsu_done frees a slot
        applyStimulus(0, 1, 1, 5'd8, 3'b001, 5'd1, 5'd0, 5'd0, CL_LD);
        #1 checkOutput("ld8_iss0", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("lsu_cnt_1", cnt, 1);
        applyStimulus(0, 1, 1, 5'd9, 3'b001, 5'd2, 5'd0, 5'd0, CL_LD);
        #1 checkOutput("ld9_iss0", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("lsu_cnt_2", cnt, 2);
        checkOutput("ld_pend", pend, 32'h0000_0300);
        applyStimulus(0, 1, 0, 5'd0, 3'b011, 5'd1, 5'd3, 5'd0, CL_ST);
        #1 checkOutput("st_lsu_full", iss0, 0);
        lsu_done = 1'b1; lsu_wb_vld = 1'b1; lsu_wb_addr = 5'd8;
        #1 checkOutput("st_on_done", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("lsu_cnt_hold", cnt, 2);
        checkOutput("ld8_cleared", pend, 32'h0000_0200);

        // Pairing rules
        applyStimulus(0, 1, 1, 5'd5, 3'b011, 5'd1, 5'd2, 5'd0, CL_ALU);
        applyStimulus(1, 1, 1, 5'd13, 3'b001, 5'd5, 5'd0, 5'd0, CL_ALU);
        #1 checkOutput("dep_iss0", iss0, 1);
        checkOutput("dep_iss1", iss1, 0);
        i1_r0 = 5'd6;
        #1 checkOutput("indep_iss1", iss1, 1);
        checkOutput("single_indep_iss1", nd_iss1, 0);
        i1_r0 = 5'd9;
        #1 checkOutput("raw_x9_iss1", iss1, 0);
        @(negedge clk); idleInputs();
        applyStimulus(0, 1, 0, 5'd0, 3'b011, 5'd1, 5'd2, 5'd0, CL_BR);
        applyStimulus(1, 1, 1, 5'd13, 3'b001, 5'd6, 5'd0, 5'd0, CL_ALU);
        #1 checkOutput("br_iss0", iss0, 1);
        checkOutput("br_iss1", iss1, 0);
        @(negedge clk); idleInputs();
        applyStimulus(0, 1, 1, 5'd3, 3'b111, 5'd1, 5'd2, 5'd4, CL_ALU);
        applyStimulus(1, 1, 1, 5'd13, 3'b011, 5'd6, 5'd7, 5'd0, CL_ALU);
        #1 checkOutput("src5_iss1", iss1, 0);
        i1_r1_vld = 1'b0;
        #1 checkOutput("src4_iss1", iss1, 1);
        @(negedge clk); idleInputs();
        applyStimulus(0, 1, 1, 5'd3, 3'b001, 5'd1, 5'd0, 5'd0, CL_CSR);
        applyStimulus(1, 1, 1, 5'd13, 3'b001, 5'd6, 5'd0, 5'd0, CL_CSR);
        #1 checkOutput("csr_pair_iss1", iss1, 0);

        // mul x0 never pends; mul x10 during div writeback to x10 keeps it pending
        @(negedge clk); idleInputs();
        applyStimulus(0, 1, 1, 5'd0, 3'b001, 5'd1, 5'd0, 5'd0, CL_MUL);
        #1 checkOutput("mul_x0_iss0", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("mul_x0_pend", pend, 32'h0000_0200);
        applyStimulus(0, 1, 1, 5'd10, 3'b001, 5'd1, 5'd0, 5'd0, CL_DIV);
        mul_wb_vld = 1'b1; mul_wb_addr = 5'd0;
        #1 checkOutput("div10_iss0", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("div10_pend", pend, 32'h0000_0600);
        applyStimulus(0, 1, 1, 5'd10, 3'b001, 5'd1, 5'd0, 5'd0, CL_MUL);
        div_wb_vld = 1'b1; div_wb_addr = 5'd10;
        #1 checkOutput("mul10_waw_bypass", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("set_wins_pend", pend, 32'h0000_0600);

        // Flush blocks issue but writebacks still retire
        applyStimulus(0, 1, 1, 5'd12, 3'b001, 5'd1, 5'd0, 5'd0, CL_DIV);
        mul_wb_vld = 1'b1; mul_wb_addr = 5'd10;
        #1 checkOutput("div12_iss0", iss0, 1);
        @(negedge clk); idleInputs();
        checkOutput("div12_pend", pend, 32'h0000_1200);
        flush = 1'b1;
        applyStimulus(0, 1, 1, 5'd3, 3'b011, 5'd1, 5'd2, 5'd0, CL_ALU);
        applyStimulus(1, 1, 1, 5'd4, 3'b001, 5'd5, 5'd0, 5'd0, CL_ALU);
        div_wb_vld = 1'b1; div_wb_addr = 5'd12;
        #1 checkOutput("flush_iss0", iss0, 0);
        checkOutput("flush_iss1", iss1, 0);
        @(negedge clk); idleInputs();
        checkOutput("flush_wb_pend", pend, 32'h0000_0200);
        checkOutput("pre_rst_lsu_cnt", cnt, 2);

        // Reset mid-operation, then a stray writeback and lsu_done are ignored
        rst = 1'b1;
        applyStimulus(0, 1, 1, 5'd3, 3'b011, 5'd1, 5'd2, 5'd0, CL_ALU);
        #1 checkOutput("rst_mid_iss0", iss0, 0);
        @(negedge clk); idleInputs();
        rst = 1'b0;
        #1 checkOutput("rst_mid_cnt", cnt, 0);
        checkOutput("rst_mid_pend", pend, 0);
        lsu_done = 1'b1; lsu_wb_vld = 1'b1; lsu_wb_addr = 5'd9;
        @(negedge clk); idleInputs();
        checkOutput("cnt_sat_zero", cnt, 0);
        checkOutput("stray_wb_pend", pend, 0);
        checkOutput("single_pend", nd_pend, 0);
        checkOutput("single_cnt", nd_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
